instr_decode_dispatch: RTL and testbench
========================================

// Module: instr_decode_dispatch
// PURPOSE
// - Parametrised successor to the single-cycle opcode decoder. Buffers incoming instructions in a small FIFO.
// - Decodes each instruction and issues it to fetch units and compute configuration over valid/ready handshakes,
//   stalling per-destination instead of dropping work.
// - Adds a barrier opcode (wait for all units idle), sticky done, and illegal-opcode flagging.
// - Sits between the instruction fetcher and the fetch/CLP/vreg blocks.
// PARAMETERS
// - INSTR_W     64  instruction width; opcode is [INSTR_W-1 -: 8], seven 8-bit fields below it (f1..f7)
// - FIFO_DEPTH  4   instruction FIFO entries, power of two, >=2
// - NUM_FETCH   4   fetch destinations: bit0 feature, bit1 weight, bit2 bias, bit3 scaler
// - ADDR_W      16  fetch source address width ({f2,f3} zero-extended/truncated)
// PORTS
// - clk            in   1               clock
// - rst            in   1               synchronous, active-high reset
// - instr_valid    in   1               instruction offered
// - instr_data     in   INSTR_W         instruction word
// - instr_ready    out  1               FIFO not full
// - fetch_valid    out  NUM_FETCH       one-hot-or-multi fetch request
// - fetch_ready    in   NUM_FETCH       per-unit accept
// - fetch_type     out  8               f1
// - fetch_src      out  ADDR_W          {f2,f3}
// - fetch_dst      out  8               {f4[3:0],f5[3:0]}
// - fetch_mem_sel  out  8               f6
// - fetch_count    out  8               f7
// - cfg_valid      out  1               conv config request
// - cfg_ready      in   1               CLP accepts config
// - kernel_size    out  4               f3[3:0]
// - feature_size   out  8               f2
// - lb_enable      out  1               f4[0]
// - lb_mod         out  1               f1[0]
// - feat_in_sel    out  1               f6[0]
// - vreg_enable    out  1               f1[0], registered on opcode 0x40
// - vreg_in_sel    out  1               f2[0], registered on opcode 0x40
// - unit_busy      in   NUM_FETCH+1     busy flags of fetch units + CLP (MSB)
// - exe_done       out  1               sticky after END
// - err_illegal    out  1               one-cycle pulse on unknown opcode
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM=IDLE, exe_done=0; rst mid-handshake drops the in-flight instruction.
// - FIFO: push when instr_valid&instr_ready; instr_ready=!full.
//   - Simultaneous push+pop when full is not allowed: ready is low when full.
//   - Push+pop when non-full/non-empty keeps count.
// - FSM IDLE: if FIFO non-empty and !exe_done, pop into the decode register -> DECODE (1 cycle).
// - DECODE on opcode:
//   - 0x02/0x04: fetch_valid = f1==0 ? 4'b0001 : {f1[2],f1[1],f1[0],1'b0}; load fields -> ISSUE_F.
//     - Zero mask (f1 nonzero but bits 2:0 clear) -> IDLE.
//   - 0x81: cfg_valid=1, load cfg fields -> ISSUE_C.
//   - 0x40: update vreg_enable/vreg_in_sel, lb_mod<=f3[0] -> IDLE.
//   - 0x44: -> BARRIER.
//   - 0x82: exe_done<=1 -> IDLE; further instructions stay buffered, are not popped until rst.
//   - 0x00: NOP -> IDLE.
//   - Other: err_illegal pulse -> IDLE.
// - ISSUE_F: each fetch_valid bit clears individually in the cycle after its fetch_ready is seen high.
//   - Fields are held stable while any bit is set; all bits clear -> IDLE.
// - ISSUE_C: cfg_valid held until cfg_ready, cleared next cycle -> IDLE.
// - BARRIER: -> IDLE when unit_busy==0 for 1 cycle (sampled); no pop meanwhile.
// - Latency: FIFO push to valid out = 3 cycles minimum (push, pop, decode).
//   - Back-to-back throughput is one instruction per 3 cycles with ready held high.
// - Config outputs (kernel_size..feat_in_sel, vreg_*) hold their last value outside handshakes.
// STRUCTURE
// - Package instr_pkg: opcode localparams, fetch bit indices, field slice widths, FSM state enum.
// - Sub-module sync_fifo (DATA_W=INSTR_W, DEPTH=FIFO_DEPTH) with count, full, empty.
// - Top: FSM + field registers + per-bit fetch_valid clear logic.
// TESTING
// - Reset with FIFO full and fetch pending -> all outputs 0, instr_ready=1 next cycle.
// - Push 0x04_00_12_34_00_05_01_10, fetch_ready=1 -> fetch_valid=0001, src=0x1234, dst=0x05, mem_sel=0x01, count=0x10.
//   - fetch_valid clears 1 cycle after ready.
// - Push f1=0x07 fetch, ready weight at t0, bias at t3, scaler at t5 -> bits clear individually; IDLE after scaler.
// - Push 0x81 (f2=0x1C,f3=3), cfg_ready low 10 cycles -> cfg_valid held with kernel_size=3, feature_size=28.
// - Fill FIFO with 5 pushes while stalled -> instr_ready=0 after 4th (or 5th incl. decode reg); no loss, order preserved.
// - 0x44 with unit_busy=00010 for 6 cycles -> next instruction issued only after busy drops.
//   - Opcode 0x99 -> err_illegal single pulse.
//   - 0x82 -> exe_done sticky, subsequent pushes not decoded.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared opcodes, field geometry and FSM states for the instruction decode/dispatch block.
package instr_pkg;

    localparam int unsigned OPC_W     = 8;
    localparam int unsigned FIELD_W   = 8;
    localparam int unsigned KERNEL_W  = 4;

    localparam logic [OPC_W-1:0] OPC_NOP     = 8'h00;
    localparam logic [OPC_W-1:0] OPC_FETCH_A = 8'h02;
    localparam logic [OPC_W-1:0] OPC_FETCH_B = 8'h04;
    localparam logic [OPC_W-1:0] OPC_VREG    = 8'h40;
    localparam logic [OPC_W-1:0] OPC_BARRIER = 8'h44;
    localparam logic [OPC_W-1:0] OPC_CFG     = 8'h81;
    localparam logic [OPC_W-1:0] OPC_END     = 8'h82;

    // Fetch destination bit positions in fetch_valid / fetch_ready
    localparam int unsigned FETCH_FEATURE = 0;
    localparam int unsigned FETCH_WEIGHT  = 1;
    localparam int unsigned FETCH_BIAS    = 2;
    localparam int unsigned FETCH_SCALER  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_ISSUE_F = 3'd2,
        ST_ISSUE_C = 3'd3,
        ST_BARRIER = 3'd4
    } state_t;

    // Opcodes that issue a fetch request
    function automatic logic is_fetch_opc(input logic [OPC_W-1:0] opc);
        return (opc == OPC_FETCH_A) || (opc == OPC_FETCH_B);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_decode_dispatch.sv
// Buffers instructions, decodes them one at a time and issues fetch/config requests over valid/ready.
module instr_decode_dispatch
    import instr_pkg::*;
#(
    parameter int unsigned INSTR_W    = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_FETCH  = 4,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr_data,
    output logic                  instr_ready,
    output logic [NUM_FETCH-1:0]  fetch_valid,
    input  logic [NUM_FETCH-1:0]  fetch_ready,
    output logic [7:0]            fetch_type,
    output logic [ADDR_W-1:0]     fetch_src,
    output logic [7:0]            fetch_dst,
    output logic [7:0]            fetch_mem_sel,
    output logic [7:0]            fetch_count,
    output logic                  cfg_valid,
    input  logic                  cfg_ready,
    output logic [3:0]            kernel_size,
    output logic [7:0]            feature_size,
    output logic                  lb_enable,
    output logic                  lb_mod,
    output logic                  feat_in_sel,
    output logic                  vreg_enable,
    output logic                  vreg_in_sel,
    input  logic [NUM_FETCH:0]    unit_busy,
    output logic                  exe_done,
    output logic                  err_illegal
);

    state_t                     state_q;
    state_t                     state_d;
    logic [INSTR_W-1:0]         dec_q;
    logic [INSTR_W-1:0]         fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic                       pop_ok_c;

    logic [OPC_W-1:0]   opc;
    logic [FIELD_W-1:0] f1, f2, f3, f4, f5, f6, f7;
    logic [NUM_FETCH-1:0] fetch_mask_c;
    logic [NUM_FETCH-1:0] fetch_left_c;

    // Next values of the registered outputs
    logic [NUM_FETCH-1:0] fetch_valid_d;
    logic [7:0]           fetch_type_d;
    logic [ADDR_W-1:0]    fetch_src_d;
    logic [7:0]           fetch_dst_d;
    logic [7:0]           fetch_mem_sel_d;
    logic [7:0]           fetch_count_d;
    logic                 cfg_valid_d;
    logic [3:0]           kernel_size_d;
    logic [7:0]           feature_size_d;
    logic                 lb_enable_d;
    logic                 lb_mod_d;
    logic                 feat_in_sel_d;
    logic                 vreg_enable_d;
    logic                 vreg_in_sel_d;
    logic                 exe_done_d;
    logic                 err_illegal_d;

    logic unused_bits;

    sync_fifo #(
        .DATA_W (INSTR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (instr_valid && instr_ready),
        .wdata (instr_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_ready = !fifo_full;
    assign pop_ok_c    = !fifo_empty && !exe_done;

    assign opc = dec_q[INSTR_W-1 -: OPC_W];
    assign f1  = dec_q[INSTR_W-1-1*FIELD_W -: FIELD_W];
    assign f2  = dec_q[INSTR_W-1-2*FIELD_W -: FIELD_W];
    assign f3  = dec_q[INSTR_W-1-3*FIELD_W -: FIELD_W];
    assign f4  = dec_q[INSTR_W-1-4*FIELD_W -: FIELD_W];
    assign f5  = dec_q[INSTR_W-1-5*FIELD_W -: FIELD_W];
    assign f6  = dec_q[INSTR_W-1-6*FIELD_W -: FIELD_W];
    assign f7  = dec_q[INSTR_W-1-7*FIELD_W -: FIELD_W];

    assign unused_bits = ^{dec_q, f4[7:4], f5[7:4], fifo_count};

    // f1==0 targets the feature unit; otherwise f1 bits map onto the units above it
    always_comb begin
        fetch_mask_c = '0;
        if (f1 == 8'h00) begin
            fetch_mask_c[FETCH_FEATURE] = 1'b1;
        end else begin
            for (int i = 1; i < int'(NUM_FETCH); i++) begin
                fetch_mask_c[i] = f1[i-1];
            end
        end
    end

    assign fetch_left_c = fetch_valid & ~fetch_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_ok_c) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_fetch_opc(opc)) begin
                    state_d = (fetch_mask_c != '0) ? ST_ISSUE_F : ST_IDLE;
                end else if (opc == OPC_CFG) begin
                    state_d = ST_ISSUE_C;
                end else if (opc == OPC_BARRIER) begin
                    state_d = ST_BARRIER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_F: begin
                if (fetch_left_c == '0) state_d = ST_IDLE;
            end
            ST_ISSUE_C: begin
                if (cfg_ready) state_d = ST_IDLE;
            end
            ST_BARRIER: begin
                if (unit_busy == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless a state updates it
    always_comb begin
        fifo_pop        = 1'b0;
        fetch_valid_d   = fetch_valid;
        fetch_type_d    = fetch_type;
        fetch_src_d     = fetch_src;
        fetch_dst_d     = fetch_dst;
        fetch_mem_sel_d = fetch_mem_sel;
        fetch_count_d   = fetch_count;
        cfg_valid_d     = cfg_valid;
        kernel_size_d   = kernel_size;
        feature_size_d  = feature_size;
        lb_enable_d     = lb_enable;
        lb_mod_d        = lb_mod;
        feat_in_sel_d   = feat_in_sel;
        vreg_enable_d   = vreg_enable;
        vreg_in_sel_d   = vreg_in_sel;
        exe_done_d      = exe_done;
        err_illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fifo_pop = pop_ok_c;
            end
            ST_DECODE: begin
                if (is_fetch_opc(opc)) begin
                    if (fetch_mask_c != '0) begin
                        fetch_valid_d   = fetch_mask_c;
                        fetch_type_d    = f1;
                        fetch_src_d     = ADDR_W'({f2, f3});
                        fetch_dst_d     = {f4[3:0], f5[3:0]};
                        fetch_mem_sel_d = f6;
                        fetch_count_d   = f7;
                    end
                end else begin
                    case (opc)
                        OPC_CFG: begin
                            cfg_valid_d    = 1'b1;
                            kernel_size_d  = f3[KERNEL_W-1:0];
                            feature_size_d = f2;
                            lb_enable_d    = f4[0];
                            lb_mod_d       = f1[0];
                            feat_in_sel_d  = f6[0];
                        end
                        OPC_VREG: begin
                            vreg_enable_d = f1[0];
                            vreg_in_sel_d = f2[0];
                            lb_mod_d      = f3[0];
                        end
                        OPC_END:     exe_done_d = 1'b1;
                        OPC_BARRIER: ;
                        OPC_NOP:     ;
                        default:     err_illegal_d = 1'b1;
                    endcase
                end
            end
            ST_ISSUE_F: begin
                fetch_valid_d = fetch_left_c;
            end
            ST_ISSUE_C: begin
                if (cfg_ready) cfg_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Decode register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q         <= '0;
            fetch_valid   <= '0;
            fetch_type    <= '0;
            fetch_src     <= '0;
            fetch_dst     <= '0;
            fetch_mem_sel <= '0;
            fetch_count   <= '0;
            cfg_valid     <= 1'b0;
            kernel_size   <= '0;
            feature_size  <= '0;
            lb_enable     <= 1'b0;
            lb_mod        <= 1'b0;
            feat_in_sel   <= 1'b0;
            vreg_enable   <= 1'b0;
            vreg_in_sel   <= 1'b0;
            exe_done      <= 1'b0;
            err_illegal   <= 1'b0;
        end else begin
            if (fifo_pop) dec_q <= fifo_rdata;
            fetch_valid   <= fetch_valid_d;
            fetch_type    <= fetch_type_d;
            fetch_src     <= fetch_src_d;
            fetch_dst     <= fetch_dst_d;
            fetch_mem_sel <= fetch_mem_sel_d;
            fetch_count   <= fetch_count_d;
            cfg_valid     <= cfg_valid_d;
            kernel_size   <= kernel_size_d;
            feature_size  <= feature_size_d;
            lb_enable     <= lb_enable_d;
            lb_mod        <= lb_mod_d;
            feat_in_sel   <= feat_in_sel_d;
            vreg_enable   <= vreg_enable_d;
            vreg_in_sel   <= vreg_in_sel_d;
            exe_done      <= exe_done_d;
            err_illegal   <= err_illegal_d;
        end
    end

endmodule

// File: tb/tb_instr_decode_dispatch.sv
// Directed testbench for instr_decode_dispatch.
module tb_instr_decode_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [63:0] instr_data;
    logic        instr_ready;
    logic [3:0]  fetch_valid;
    logic [3:0]  fetch_ready;
    logic [7:0]  fetch_type;
    logic [15:0] fetch_src;
    logic [7:0]  fetch_dst;
    logic [7:0]  fetch_mem_sel;
    logic [7:0]  fetch_count;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  kernel_size;
    logic [7:0]  feature_size;
    logic        lb_enable;
    logic        lb_mod;
    logic        feat_in_sel;
    logic        vreg_enable;
    logic        vreg_in_sel;
    logic [4:0]  unit_busy;
    logic        exe_done;
    logic        err_illegal;

    logic [71:0] all_outs;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign all_outs = {fetch_valid, fetch_type, fetch_src, fetch_dst, fetch_mem_sel, fetch_count,
                       cfg_valid, kernel_size, feature_size, lb_enable, lb_mod, feat_in_sel,
                       vreg_enable, vreg_in_sel, exe_done, err_illegal};

    instr_decode_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_ready   (instr_ready),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_type    (fetch_type),
        .fetch_src     (fetch_src),
        .fetch_dst     (fetch_dst),
        .fetch_mem_sel (fetch_mem_sel),
        .fetch_count   (fetch_count),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .kernel_size   (kernel_size),
        .feature_size  (feature_size),
        .lb_enable     (lb_enable),
        .lb_mod        (lb_mod),
        .feat_in_sel   (feat_in_sel),
        .vreg_enable   (vreg_enable),
        .vreg_in_sel   (vreg_in_sel),
        .unit_busy     (unit_busy),
        .exe_done      (exe_done),
        .err_illegal   (err_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        instr_valid = 1'b1;
        instr_data  = d;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr_data = '0;
        fetch_ready = '0; cfg_ready = 1'b0; unit_busy = '0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (all_outs !== 72'd0) begin n_err++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        n_cmp++;
        if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_fetch_basic();
        fetch_ready = 4'hF;
        push(64'h04_00_12_34_00_05_01_10);
        tick();
        n_cmp++;
        if (fetch_valid !== 4'b0000) begin n_err++; $display("FAIL basic_early: got %b want 0000", fetch_valid); end
        tick();
        n_cmp++;
        if (fetch_valid !== 4'b0001) begin n_err++; $display("FAIL basic_mask: got %b want 0001", fetch_valid); end
        n_cmp++;
        if ({fetch_src, fetch_dst, fetch_mem_sel, fetch_count} !== {16'h1234, 8'h05, 8'h01, 8'h10}) begin
            n_err++;
            $display("FAIL basic_fields: got %h %h %h %h want 1234 05 01 10", fetch_src, fetch_dst, fetch_mem_sel, fetch_count);
        end
        tick();
        n_cmp++;
        if (fetch_valid !== 4'b0000) begin n_err++; $display("FAIL basic_clear: got %b want 0000", fetch_valid); end
    endtask

    task automatic test_fetch_multi();
        fetch_ready = 4'h0;
        push(64'h02_07_AB_CD_00_00_00_00);
        tick(); tick();
        n_cmp++;
        if (fetch_valid !== 4'b1110) begin n_err++; $display("FAIL multi_mask: got %b want 1110", fetch_valid); end
        fetch_ready = 4'b0010;
        tick();
        fetch_ready = 4'b0000;
        n_cmp++;
        if (fetch_valid !== 4'b1100) begin n_err++; $display("FAIL multi_weight: got %b want 1100", fetch_valid); end
        tick(); tick();
        n_cmp++;
        if (fetch_valid !== 4'b1100 || fetch_src !== 16'hABCD) begin
            n_err++; $display("FAIL multi_hold: got %b %h want 1100 abcd", fetch_valid, fetch_src);
        end
        fetch_ready = 4'b0100;
        tick();
        fetch_ready = 4'b0000;
        n_cmp++;
        if (fetch_valid !== 4'b1000) begin n_err++; $display("FAIL multi_bias: got %b want 1000", fetch_valid); end
        tick();
        fetch_ready = 4'b1000;
        tick();
        fetch_ready = 4'b0000;
        n_cmp++;
        if (fetch_valid !== 4'b0000) begin n_err++; $display("FAIL multi_scaler: got %b want 0000", fetch_valid); end
    endtask

    task automatic test_cfg();
        logic held;
        cfg_ready = 1'b0;
        push(64'h81_01_1C_03_01_00_01_00);
        tick(); tick();
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (cfg_valid !== 1'b1) held = 1'b0;
            tick();
        end
        n_cmp++;
        if (held !== 1'b1) begin n_err++; $display("FAIL cfg_held: got %b want 1", held); end
        n_cmp++;
        if ({kernel_size, feature_size, lb_enable, lb_mod, feat_in_sel} !== {4'd3, 8'd28, 3'b111}) begin
            n_err++;
            $display("FAIL cfg_fields: got k=%0d f=%0d lb=%b mod=%b sel=%b want 3 28 1 1 1",
                     kernel_size, feature_size, lb_enable, lb_mod, feat_in_sel);
        end
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        n_cmp++;
        if (cfg_valid !== 1'b0 || kernel_size !== 4'd3) begin
            n_err++; $display("FAIL cfg_release: got v=%b k=%0d want 0 3", cfg_valid, kernel_size);
        end
    endtask

    task automatic test_vreg();
        push(64'h40_01_01_00_00_00_00_00);
        tick(); tick();
        n_cmp++;
        if ({vreg_enable, vreg_in_sel, lb_mod, kernel_size} !== {3'b110, 4'd3}) begin
            n_err++;
            $display("FAIL vreg: got en=%b sel=%b mod=%b k=%0d want 1 1 0 3", vreg_enable, vreg_in_sel, lb_mod, kernel_size);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_cnt [5];
        logic [7:0] got_cnt [$];
        int         got_cyc [$];
        exp_cnt = '{8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        fetch_ready = 4'h0;
        push(64'h04_00_00_00_00_00_00_A0);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (instr_ready !== (i < 4)) begin
                n_err++; $display("FAIL fill_ready%0d: got %b want %b", i, instr_ready, (i < 4));
            end
            push({56'h04_00_00_00_00_00_00, 8'hB1 + 8'(i)});
        end
        n_cmp++;
        if (instr_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b want 0", instr_ready); end
        fetch_ready = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            if (fetch_valid[0] === 1'b1) begin
                got_cnt.push_back(fetch_count);
                got_cyc.push_back(c);
            end
            tick();
        end
        n_cmp++;
        if (got_cnt.size() !== 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", got_cnt.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_cnt.size()) begin
                n_cmp++;
                if (got_cnt[i] !== exp_cnt[i]) begin
                    n_err++; $display("FAIL b2b_order%0d: got %h want %h", i, got_cnt[i], exp_cnt[i]);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (got_cyc[i] - got_cyc[i-1] !== 3) begin
                        n_err++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, got_cyc[i] - got_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_barrier();
        logic leaked;
        int   waited;
        fetch_ready = 4'hF;
        unit_busy   = 5'b00010;
        push(64'h44_00_00_00_00_00_00_00);
        push(64'h04_00_00_00_00_00_00_C7);
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fetch_valid !== 4'b0000) leaked = 1'b1;
        end
        n_cmp++;
        if (leaked !== 1'b0) begin n_err++; $display("FAIL barrier_block: got %b want 0", leaked); end
        unit_busy = '0;
        waited = 0;
        while (fetch_valid === 4'b0000 && waited < 10) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (fetch_valid !== 4'b0001 || fetch_count !== 8'hC7 || waited !== 3) begin
            n_err++;
            $display("FAIL barrier_release: got v=%b cnt=%h wait=%0d want 0001 c7 3", fetch_valid, fetch_count, waited);
        end
        tick();
    endtask

    task automatic test_illegal();
        push(64'h99_00_00_00_00_00_00_00);
        tick();
        n_cmp++;
        if (err_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_early: got %b want 0", err_illegal); end
        tick();
        n_cmp++;
        if (err_illegal !== 1'b1) begin n_err++; $display("FAIL illegal_pulse: got %b want 1", err_illegal); end
        tick();
        n_cmp++;
        if (err_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_clear: got %b want 0", err_illegal); end
    endtask

    task automatic test_reset_midflight();
        fetch_ready = 4'h0;
        push(64'h04_00_00_00_00_00_00_11);
        tick(); tick();
        for (int i = 0; i < 4; i++) push({56'h04_00_00_00_00_00_00, 8'h20 + 8'(i)});
        n_cmp++;
        if (fetch_valid !== 4'b0001 || instr_ready !== 1'b0) begin
            n_err++; $display("FAIL pre_reset: got v=%b rdy=%b want 0001 0", fetch_valid, instr_ready);
        end
        rst = 1'b1;
        instr_valid = 1'b1;
        instr_data  = 64'h04_00_00_00_00_00_00_77;
        tick();
        rst = 1'b0;
        instr_valid = 1'b0;
        n_cmp++;
        if (all_outs !== 72'd0 || instr_ready !== 1'b1) begin
            n_err++; $display("FAIL midflight_reset: got %h rdy=%b want 0 1", all_outs, instr_ready);
        end
        fetch_ready = 4'hF;
        push(64'h04_00_00_00_00_00_00_E1);
        tick(); tick();
        n_cmp++;
        if (fetch_valid !== 4'b0001 || fetch_count !== 8'hE1) begin
            n_err++; $display("FAIL after_reset: got v=%b cnt=%h want 0001 e1", fetch_valid, fetch_count);
        end
        tick();
    endtask

    task automatic test_done();
        logic leaked;
        fetch_ready = 4'hF;
        push(64'h82_00_00_00_00_00_00_00);
        tick(); tick();
        n_cmp++;
        if (exe_done !== 1'b1) begin n_err++; $display("FAIL done_set: got %b want 1", exe_done); end
        push(64'h04_00_00_00_00_00_00_D0);
        leaked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fetch_valid !== 4'b0000) leaked = 1'b1;
            tick();
        end
        n_cmp++;
        if (leaked !== 1'b0 || exe_done !== 1'b1) begin
            n_err++; $display("FAIL done_sticky: got leak=%b done=%b want 0 1", leaked, exe_done);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_fetch_multi();
        test_cfg();
        test_vreg();
        test_back_to_back();
        test_barrier();
        test_illegal();
        test_reset_midflight();
        test_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
